mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port system RAM. Shares the memory between the CPU bus port (MAR/MDR path driven by the control unit's Read/Write) and an I/O-DMA port (program loader, in/out-port buffering). Grants round-robin, drives the RAM's enable/address/data for exactly one cycle, waits the RAM's fixed read latency, then returns a one-cycle acknowledge with registered read data.

## Interface
- ADDR_W, 9, word address width (512-word RAM)
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles (legal range 1..7)

- Clock  in  1  single clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  2  per-port request, bit 0 = CPU, bit 1 = DMA; level, held until Ack
- We  in  2  per-port write (1) / read (0) qualifier, valid with Req
- Addr0, Addr1  in  ADDR_W  per-port word address
- WData0, WData1  in  DATA_W  per-port write data
- Ack  out  2  one-cycle completion pulse to the granted port
- RData  out  DATA_W  read data, valid in Ack cycle, held until next read completes
- Busy  out  1  high in every state except IDLE
- Owner  out  1  port index of current/last grant
- MemAddr  out  ADDR_W  RAM address
- MemWData  out  DATA_W  RAM write data
- MemRe, MemWe  out  1  RAM read / write strobes
- MemRData  in  DATA_W  RAM read data, valid RD_LAT cycles after MemRe cycle

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any Req bit is set, pick winner, latch its Addr/WData/We into internal registers, set Owner, go ACCESS; else stay.
- Arbitration: round-robin pointer Pri (reset 0 = CPU favoured). One requester → that one wins. Both → port Pri wins. After each grant Pri = ~winner.
- ACCESS (1 cycle): MemAddr/MemWData from latched values; MemWe = latched We, MemRe = ~latched We. Write → DONE. Read → WAIT, load counter with RD_LAT.
- WAIT: decrement counter each cycle; on the cycle counter = 1, capture MemRData into RData, go DONE.
- DONE (1 cycle): Ack[Owner] = 1, go IDLE.
- Req is only sampled in IDLE. Req held high past Ack is treated as a new request in the next IDLE cycle. Req dropped mid-transaction: transaction still completes and Ack still pulses.
- Inputs changing after latching in IDLE have no effect on the transaction in flight.
- RData is not changed by writes.
- Reset values: state IDLE, Pri 0, Owner 0, counter 0, RData 0. Ack, MemRe, MemWe, Busy all 0. MemAddr, MemWData 0.
- Reset_n low mid-transaction: immediate return to IDLE. Strobes and Ack drop asynchronously. No Ack is issued for the aborted access.

## Timing
- Write: Req sampled at edge ending cycle 0 (IDLE). Cycle 1 ACCESS with MemWe = 1. Cycle 2 DONE with Ack = 1. The next IDLE is in cycle 3.
- Read: cycle 1 ACCESS with MemRe = 1. Cycles 2..1+RD_LAT are WAIT. Cycle 2+RD_LAT is DONE with Ack and RData valid.
- Throughput: one write per 3 cycles, one read per 3+RD_LAT cycles; IDLE always lasts at least one cycle between transactions.
- All outputs are registered or decoded from state only. There is no combinational path from Req to Mem* or Ack.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3)
  - port indices PORT_CPU = 0, PORT_DMA = 1
- Sub-module mem_arb_rr2: combinational 2-way round-robin pick (Req, Pri → winner, valid). The FSM, latches, latency counter and RData register stay in the top.

## Test plan
- CPU-only write: Req = 01, We = 01, Addr0 = 9'h010, WData0 = 32'hDEADBEEF → MemWe high for exactly one cycle with MemAddr = 010; Ack = 01 two cycles after sampling; RAM[010] = DEADBEEF.
- CPU-only read of 010, RD_LAT = 1 → MemRe one cycle; Ack = 01 three cycles after sampling with RData = DEADBEEF; Busy high for 3 cycles.
- Simultaneous requests, three rounds (Req = 11 held, alternating ports re-asserting after Ack) → grants in order CPU, DMA, CPU; Owner matches each Ack; no port starves.
- Req dropped in the ACCESS cycle of a DMA write (Addr1 = 9'h1FF, WData1 = 32'h5) → write still performed, Ack = 10 still pulses; Addr1 changed during the transaction has no effect.
- Reset_n pulsed low during WAIT of a read → MemRe/Ack low immediately; state IDLE, Pri 0, RData 0; no Ack issued after release.
- RD_LAT = 3 build, read of a preloaded word 32'h12345678 → Ack exactly 5 cycles after sampling, RData = 12345678.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the system RAM port arbiter
// Purpose: sequencer state encoding and requester port indices used by
// mem_port_arbiter and mem_arb_rr2.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - combinational two-way round-robin pick
// Purpose: choose which of the CPU / DMA requesters gets the RAM next.
// Ports:
//   req    in  2  request bits, bit 0 = CPU, bit 1 = DMA
//   pri    in  1  port favoured when both request
//   winner out 1  index of the chosen port (meaningful only when valid)
//   valid  out 1  at least one request present
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pri,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    case (req)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_DMA;
      2'b11:   winner = pri;
      default: winner = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU / DMA arbiter and sequencer for the single-port RAM
// Purpose: grant the RAM round-robin, issue one access strobe, wait the RAM's
// read latency, then pulse a one-cycle acknowledge with registered read data.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req[1:0], we[1:0]    per-port request / write qualifier (0 = CPU, 1 = DMA)
//   addr0/1, wdata0/1    per-port address and write data
//   ack[1:0]             one-cycle completion pulse to the granted port
//   rdata                read data, held until the next read completes
//   busy, owner          sequencer active / current-or-last granted port
//   mem_addr, mem_wdata  RAM address and write data
//   mem_re, mem_we       RAM read / write strobes
//   mem_rdata            RAM read data, valid RD_LAT cycles after mem_re
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  logic       pri;
  logic       lat_we;
  logic [2:0] cnt;
  logic       winner;
  logic       valid;

  mem_arb_rr2 u_rr (
    .req    (req),
    .pri    (pri),
    .winner (winner),
    .valid  (valid)
  );

  // mem_addr / mem_wdata double as the latched transaction registers, so the
  // requester's inputs are free to change once the grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pri       <= PORT_CPU;
      owner     <= PORT_CPU;
      lat_we    <= 1'b0;
      cnt       <= 3'd0;
      rdata     <= '0;
      ack       <= 2'b00;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            owner     <= winner;
            pri       <= ~winner;
            mem_addr  <= winner ? addr1 : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            lat_we    <= we[winner];
            // strobes are registered here so they appear in the ACCESS cycle
            mem_we    <= we[winner];
            mem_re    <= ~we[winner];
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (lat_we) begin
            ack   <= 2'b01 << owner;
            state <= DONE;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // count of 1 marks the cycle in which the RAM data is valid
          if (cnt == 3'd1) begin
            rdata <= mem_rdata;
            ack   <= 2'b01 << owner;
            state <= DONE;
          end
        end
        DONE: begin
          ack   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req, req3, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic [1:0]    ack, ack_3;
  logic [DW-1:0] rdata, rdata_3;
  logic          busy, busy_3, owner, owner_3;
  logic [AW-1:0] mem_addr, mem_addr_3;
  logic [DW-1:0] mem_wdata, mem_wdata_3;
  logic          mem_re, mem_re_3, mem_we, mem_we_3;
  logic [DW-1:0] mem_rdata, mem_rdata_3;

  logic [DW-1:0] ram1 [0:511];
  logic [DW-1:0] ram3 [0:511];
  logic [DW-1:0] p0, p1, p2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .owner(owner),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_3), .rdata(rdata_3), .busy(busy_3), .owner(owner_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_rdata(mem_rdata_3)
  );

  // RAM models: one-cycle and three-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram1[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram1[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we_3) ram3[mem_addr_3] <= mem_wdata_3;
    if (mem_re_3) p0 <= ram3[mem_addr_3];
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata_3 = p2;

  typedef struct {
    logic [1:0]  ack;
    logic        owner;
    bit          rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input logic [1:0] a, input logic o, input bit rd,
                            input logic [31:0] d, input int lat);
    exp_t e;
    e.ack = a; e.owner = o; e.rd = rd; e.data = d; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for an ack on the selected instance, tallying strobes,
  // then pops the scoreboard and compares.
  task automatic wait_ack(input bit sel, input string tag, output int nbusy,
                          output int nre, output int nwe, output logic [31:0] acc_addr);
    exp_t e;
    int n;
    bit seen;
    logic [1:0] a;
    n = 0; nbusy = 0; nre = 0; nwe = 0; seen = 0; acc_addr = '1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (sel ? busy_3 : busy) nbusy++;
      if (sel ? mem_re_3 : mem_re) nre++;
      if (sel ? mem_we_3 : mem_we) nwe++;
      if ((sel ? mem_re_3 : mem_re) || (sel ? mem_we_3 : mem_we))
        acc_addr = 32'(sel ? mem_addr_3 : mem_addr);
      a = sel ? ack_3 : ack;
      if (a != 2'b00) seen = 1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_ack"}, 32'(a), 32'(e.ack));
      check({tag, "_owner"}, 32'(sel ? owner_3 : owner), 32'(e.owner));
      check({tag, "_latency"}, 32'(n), 32'(e.lat));
      if (e.rd) check({tag, "_rdata"}, sel ? rdata_3 : rdata, e.data);
    end
  endtask

  initial begin
    int nb, nr, nw, pulses;
    logic [31:0] aa;
    req = 2'b00; req3 = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ack3", 32'(ack_3), 32'd0);
    check("rst_busy3", 32'(busy_3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU-only write
    we = 2'b01; addr0 = 9'h010; wdata0 = 32'hDEADBEEF; req = 2'b01;
    expect_txn(2'b01, 1'b0, 0, 32'd0, 2);
    wait_ack(0, "cpu_wr", nb, nr, nw, aa);
    req = 2'b00;
    check("cpu_wr_we_cycles", 32'(nw), 32'd1);
    check("cpu_wr_re_cycles", 32'(nr), 32'd0);
    check("cpu_wr_busy", 32'(nb), 32'd2);
    check("cpu_wr_addr", aa, 32'h010);
    check("cpu_wr_ram", ram1[9'h010], 32'hDEADBEEF);
    @(negedge clk);

    // CPU-only read, RD_LAT = 1
    we = 2'b00; addr0 = 9'h010; req = 2'b01;
    expect_txn(2'b01, 1'b0, 1, 32'hDEADBEEF, 3);
    wait_ack(0, "cpu_rd", nb, nr, nw, aa);
    req = 2'b00;
    check("cpu_rd_re_cycles", 32'(nr), 32'd1);
    check("cpu_rd_we_cycles", 32'(nw), 32'd0);
    check("cpu_rd_busy", 32'(nb), 32'd3);
    check("cpu_rd_addr", aa, 32'h010);
    @(negedge clk);

    // reset, then three rounds of simultaneous requests
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdata_cleared", rdata, 32'd0);
    we = 2'b11; addr0 = 9'h020; addr1 = 9'h021;
    wdata0 = 32'h000000A0; wdata1 = 32'h000000B1; req = 2'b11;
    expect_txn(2'b01, 1'b0, 0, 32'd0, 2);
    expect_txn(2'b10, 1'b1, 0, 32'd0, 3);
    expect_txn(2'b01, 1'b0, 0, 32'd0, 3);
    for (int k = 0; k < 3; k++) wait_ack(0, "rr", nb, nr, nw, aa);
    req = 2'b00;
    check("rr_ram_cpu", ram1[9'h020], 32'h000000A0);
    check("rr_ram_dma", ram1[9'h021], 32'h000000B1);
    check("rr_rdata_untouched", rdata, 32'd0);
    @(negedge clk);

    // DMA write, request dropped and inputs changed in the ACCESS cycle
    we = 2'b10; addr1 = 9'h1FF; wdata1 = 32'h5; req = 2'b10;
    expect_txn(2'b10, 1'b1, 0, 32'd0, 1);
    @(negedge clk);
    check("dma_wr_we", 32'(mem_we), 32'd1);
    check("dma_wr_addr", 32'(mem_addr), 32'h1FF);
    check("dma_wr_wdata", mem_wdata, 32'h5);
    req = 2'b00; addr1 = 9'h055; wdata1 = 32'h99;
    wait_ack(0, "dma_wr", nb, nr, nw, aa);
    check("dma_wr_ram", ram1[9'h1FF], 32'h5);
    @(negedge clk);

    // CPU read of 1FF loads rdata before the abort test
    we = 2'b00; addr0 = 9'h1FF; req = 2'b01;
    expect_txn(2'b01, 1'b0, 1, 32'h5, 3);
    wait_ack(0, "rd_1ff", nb, nr, nw, aa);
    req = 2'b00;
    @(negedge clk);

    // read aborted by reset during WAIT
    we = 2'b00; addr0 = 9'h010; req = 2'b01;
    @(negedge clk);
    check("abort_re_access", 32'(mem_re), 32'd1);
    @(negedge clk);
    check("abort_busy_wait", 32'(busy), 32'd1);
    req = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_re", 32'(mem_re), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 2'b00) pulses++;
    end
    check("abort_no_ack", 32'(pulses), 32'd0);

    // pointer back to CPU after reset
    we = 2'b11; addr0 = 9'h030; addr1 = 9'h031; req = 2'b11;
    expect_txn(2'b01, 1'b0, 0, 32'd0, 2);
    wait_ack(0, "pri_rst", nb, nr, nw, aa);
    req = 2'b00;
    @(negedge clk);

    // RD_LAT = 3 instance: write then read back
    we = 2'b01; addr0 = 9'h0AB; wdata0 = 32'h12345678; req3 = 2'b01;
    expect_txn(2'b01, 1'b0, 0, 32'd0, 2);
    wait_ack(1, "lat3_wr", nb, nr, nw, aa);
    req3 = 2'b00;
    @(negedge clk);
    we = 2'b00; req3 = 2'b01;
    expect_txn(2'b01, 1'b0, 1, 32'h12345678, 5);
    wait_ack(1, "lat3_rd", nb, nr, nw, aa);
    req3 = 2'b00;
    check("lat3_re_cycles", 32'(nr), 32'd1);
    check("lat3_busy", 32'(nb), 32'd5);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
